core_sequencer: RTL and testbench
=================================

// Module: core_sequencer
// PURPOSE
//  Multi-cycle control FSM for the 9-bit core: owns PC and instruction register (IR).
//  Per instruction: fetch from IMEM, present IR to the decoder, strobe the datapath.
//  Runs the data-memory handshake for LW/SW and stops on HALT.
//  Sits between instruction memory, decoder, register file and data memory.
// PARAMETERS
//  PC_W     10  program-counter width (instruction words)
//  INSTR_W  9   instruction width
//  START_PC 0   PC value loaded on reset and on start
//  CNT_W    16  cycle-counter width
// PORTS
//  clk           in   1        single clock, rising edge
//  rst_n         in   1        asynchronous, active-low reset
//  start         in   1        pulse: leave IDLE/HALTED, restart at START_PC
//  imem_req      out  1        instruction fetch request, address = pc
//  imem_ack      in   1        fetch data valid on imem_rdata this cycle
//  imem_rdata    in   INSTR_W  fetched instruction
//  pc            out  PC_W     current PC
//  ir            out  INSTR_W  latched instruction, drives decoder
//  dec_branch    in   1        from decoder
//  dec_mem_read  in   1        from decoder
//  dec_mem_write in   1        from decoder
//  dec_reg_write in   1        from decoder
//  dec_halt      in   1        from decoder
//  br_taken      in   1        datapath branch condition, valid in EXEC
//  br_target     in   PC_W     absolute branch target, valid in EXEC
//  dmem_req      out  1        data-memory request
//  dmem_we       out  1        1 = write (SW), 0 = read (LW); valid while dmem_req=1
//  dmem_ack      in   1        data-memory completion
//  rf_we         out  1        one-cycle register-file write strobe
//  busy          out  1        1 in any state except IDLE/HALTED
//  halted        out  1        1 in HALTED
//  cycle_count   out  CNT_W    cycles spent while busy; saturates at all-ones
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, pc=START_PC, ir=0, cycle_count=0.
//   - All request/strobe outputs 0; busy=0, halted=0.
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED. All outputs are registered or state-decoded.
//  IDLE:   start=1 -> FETCH, pc<=START_PC, cycle_count<=0.
//  FETCH:  imem_req=1. On imem_ack: ir<=imem_rdata -> DECODE. No timeout; waits indefinitely.
//  DECODE: one cycle so the decoder settles.
//   - dec_halt -> HALTED; pc is not advanced.
//   - otherwise -> EXEC.
//  EXEC:   one cycle, ALU evaluates.
//   - next_pc = (dec_branch & br_taken) ? br_target : pc+1, modulo 2^PC_W (wraps).
//   - dec_mem_read | dec_mem_write -> MEM.
//   - else dec_reg_write -> WB.
//   - else pc<=next_pc -> FETCH.
//  MEM:    dmem_req=1, dmem_we=dec_mem_write.
//   - If both dec_mem_read and dec_mem_write are set, read wins (dmem_we=0).
//   - On dmem_ack: dec_mem_read -> WB; else pc<=next_pc -> FETCH.
//  WB:     rf_we=1 for exactly this one cycle; pc<=next_pc -> FETCH.
//  HALTED: halted=1, busy=0, no requests.
//   - start=1 -> FETCH with pc<=START_PC, cycle_count<=0.
//  Timing and boundaries:
//   - next_pc is registered in EXEC so MEM/WB never resample br_*.
//   - Minimum latency: ALU op = 4 cycles (FETCH/DECODE/EXEC/WB) with a 0-wait ack; LW = 5.
//   - start while busy is ignored.
//   - An ack arriving in a state that does not request it is ignored.
//   - rst_n low mid-transaction: requests drop the same cycle (async); no rf_we is issued.
//   - cycle_count increments each cycle busy=1 and holds at 2^CNT_W-1.
// STRUCTURE
//  Shared package (core_pkg):
//   - state_t enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED).
//   - Constants for instruction width and PC width.
//  Sub-module pc_unit: holds the pc register and computes next_pc and the wrap.
//  FSM, IR and counter stay in core_sequencer.
// TESTING
//  1. Reset, start, IR=ADD, 0-wait acks -> rf_we pulses in cycle 4 after FETCH entry; pc 0->1.
//  2. IR=LW, dmem_ack delayed 3 cycles -> dmem_req held 3 cycles, dmem_we=0, then rf_we once; pc+1.
//  3. IR=SW -> dmem_we=1, no rf_we, pc+1 after ack.
//  4. Branch with br_taken=1, br_target=0x2A5 -> pc=0x2A5; with br_taken=0 -> pc+1.
//  5. pc=0x3FF, non-branch op -> pc wraps to 0x000.
//  6. HALT opcode -> halted=1, pc unchanged, cycle_count frozen; start -> pc=0 and count cleared.
//  7. rst_n low during MEM wait -> dmem_req=0 immediately; state=IDLE; no rf_we.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared types and widths for the 9-bit core sequencer.
//               state_t     - sequencer FSM state encoding
//               INSTR_W_DEF - default instruction width
//               PC_W_DEF    - default program-counter width
//               CNT_W_DEF   - default busy-cycle counter width
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int INSTR_W_DEF = 9;
    localparam int PC_W_DEF    = 10;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6
    } state_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Program-counter register plus the registered next-PC value.
//               next_pc is captured in EXEC so later states never resample
//               the branch inputs; the +1 path wraps modulo 2^PC_W.
// Ports       : clk, rst_n        - clock, async active-low reset
//               load_start        - reload pc with START_PC
//               latch_next        - EXEC cycle: capture next_pc
//               branch_sel        - take br_target instead of pc+1
//               br_target         - absolute branch target
//               advance           - commit next_pc into pc
//               pc                - current program counter
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
    import core_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_start,
    input  logic            latch_next,
    input  logic            branch_sel,
    input  logic [PC_W-1:0] br_target,
    input  logic            advance,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] next_pc_q;
    logic [PC_W-1:0] next_pc_comb;

    // Natural modulo-2^PC_W wrap of the increment.
    assign next_pc_comb = branch_sel ? br_target : (pc + {{(PC_W-1){1'b0}}, 1'b1});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= START_PC;
            next_pc_q <= START_PC;
        end else begin
            if (latch_next) begin
                next_pc_q <= next_pc_comb;
            end
            if (load_start) begin
                pc <= START_PC;
            end else if (advance) begin
                // Leaving EXEC directly: the registered copy is not yet valid.
                pc <= latch_next ? next_pc_comb : next_pc_q;
            end
        end
    end

endmodule : pc_unit
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer
// Description : Multi-cycle control FSM for the 9-bit core. Fetches from
//               IMEM into IR, lets the decoder settle, strobes the datapath,
//               runs the LW/SW data-memory handshake and stops on HALT.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               start                       - leave IDLE/HALTED at START_PC
//               imem_req/ack/rdata          - instruction fetch handshake
//               pc, ir                      - program counter, latched instr
//               dec_*                       - decoder control inputs
//               br_taken, br_target         - branch condition/target (EXEC)
//               dmem_req/we/ack             - data-memory handshake
//               rf_we                       - one-cycle register write strobe
//               busy, halted, cycle_count   - status
// Revision    : 1.0 - initial release
// ============================================================================
module core_sequencer
    import core_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] START_PC = '0,
    parameter int              CNT_W    = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ir,
    input  logic               dec_branch,
    input  logic               dec_mem_read,
    input  logic               dec_mem_write,
    input  logic               dec_reg_write,
    input  logic               dec_halt,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic               rf_we,
    output logic               busy,
    output logic               halted,
    output logic [CNT_W-1:0]   cycle_count
);

    state_t state, next_state;
    logic   load_start;
    logic   latch_next;
    logic   advance;
    logic   ir_load;

    pc_unit #(
        .PC_W     (PC_W),
        .START_PC (START_PC)
    ) u_pc_unit (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .latch_next (latch_next),
        .branch_sel (dec_branch & br_taken),
        .br_target  (br_target),
        .advance    (advance),
        .pc         (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load_start = 1'b0;
        latch_next = 1'b0;
        advance    = 1'b0;
        ir_load    = 1'b0;
        case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    load_start = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_load    = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                next_state = dec_halt ? S_HALTED : S_EXEC;
            end
            S_EXEC: begin
                latch_next = 1'b1;
                if (dec_mem_read || dec_mem_write) begin
                    next_state = S_MEM;
                end else if (dec_reg_write) begin
                    next_state = S_WB;
                end else begin
                    advance    = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (dec_mem_read) begin
                        next_state = S_WB;
                    end else begin
                        advance    = 1'b1;
                        next_state = S_FETCH;
                    end
                end
            end
            S_WB: begin
                advance    = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // All handshake outputs are decoded from the state register, so an async
    // reset drops them in the same cycle.
    assign imem_req = (state == S_FETCH);
    assign dmem_req = (state == S_MEM);
    assign dmem_we  = (state == S_MEM) && dec_mem_write && !dec_mem_read;
    assign rf_we    = (state == S_WB);
    assign halted   = (state == S_HALTED);
    assign busy     = (state != S_IDLE) && (state != S_HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir          <= '0;
            cycle_count <= '0;
        end else begin
            if (ir_load) begin
                ir <= imem_rdata;
            end
            if (load_start) begin
                cycle_count <= '0;
            end else if (busy && (cycle_count != {CNT_W{1'b1}})) begin
                cycle_count <= cycle_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule : core_sequencer
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_sequencer
// Description : Self-checking bench for core_sequencer. A small decoder model
//               drives dec_* from ir (opcode = ir[8:6]: 0 ADD, 1 LW, 2 SW,
//               3 BR, 4 HALT). Expected outcomes are queued when an
//               instruction is issued and popped when it retires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_sequencer;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int CNT_W   = 16;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_LW   = 3'd1;
    localparam logic [2:0] OP_SW   = 3'd2;
    localparam logic [2:0] OP_BR   = 3'd3;
    localparam logic [2:0] OP_HALT = 3'd4;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               imem_req;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic               dec_branch;
    logic               dec_mem_read;
    logic               dec_mem_write;
    logic               dec_reg_write;
    logic               dec_halt;
    logic               br_taken;
    logic [PC_W-1:0]    br_target;
    logic               dmem_req;
    logic               dmem_we;
    logic               dmem_ack;
    logic               rf_we;
    logic               busy;
    logic               halted;
    logic [CNT_W-1:0]   cycle_count;

    core_sequencer #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .START_PC ('0),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .ir            (ir),
        .dec_branch    (dec_branch),
        .dec_mem_read  (dec_mem_read),
        .dec_mem_write (dec_mem_write),
        .dec_reg_write (dec_reg_write),
        .dec_halt      (dec_halt),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ack      (dmem_ack),
        .rf_we         (rf_we),
        .busy          (busy),
        .halted        (halted),
        .cycle_count   (cycle_count)
    );

    // Decoder model
    assign dec_reg_write = (ir[8:6] == OP_ADD) || (ir[8:6] == OP_LW);
    assign dec_mem_read  = (ir[8:6] == OP_LW);
    assign dec_mem_write = (ir[8:6] == OP_SW);
    assign dec_branch    = (ir[8:6] == OP_BR);
    assign dec_halt      = (ir[8:6] == OP_HALT);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [PC_W-1:0] pc;
        int              rf;
        int              dcyc;
        logic            dwe;
        int              end_n;
        logic            halt;
    } exp_t;

    exp_t            sbq[$];
    logic [PC_W-1:0] m_pc;
    int              busy_total;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Issue one instruction, follow it to retirement, compare with the queue.
    task automatic run_instr(input logic [2:0] op, input logic bt, input logic [PC_W-1:0] tgt,
                             input int wt, input logic poke_start);
        exp_t e;
        exp_t got_e;
        logic is_mem;
        logic is_rf;
        int   n;
        int   rfc;
        int   dc;
        int   rf_lat;
        logic dwe_seen;
        logic done;
        int   guard;

        is_mem  = (op == OP_LW) || (op == OP_SW);
        is_rf   = (op == OP_ADD) || (op == OP_LW);
        e.halt  = (op == OP_HALT);
        e.pc    = e.halt ? m_pc : ((op == OP_BR) && bt) ? tgt : m_pc + 10'd1;
        e.rf    = is_rf ? 1 : 0;
        e.dcyc  = is_mem ? wt : 0;
        e.dwe   = (op == OP_SW);
        e.end_n = e.halt ? 3 : 3 + (is_mem ? wt : 0) + (is_rf ? 1 : 0) + 1;
        sbq.push_back(e);

        guard = 0;
        while (!imem_req && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!imem_req) begin
            check_eq("fetch_timeout", 32'd0, 32'd1);
            void'(sbq.pop_front());
            return;
        end

        imem_ack   = 1'b1;
        imem_rdata = {op, 6'h15};
        br_taken   = bt;
        br_target  = tgt;
        n = 1; rfc = 0; dc = 0; rf_lat = 0; dwe_seen = 1'b0; done = 1'b0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            if (poke_start) start = (n == 3);
            // Scramble branch inputs after EXEC to expose any resampling.
            if (n == 4) begin
                br_taken  = ~bt;
                br_target = ~tgt;
            end
            if (dmem_req) begin
                dc++;
                dwe_seen = dmem_we;
                if (dc >= wt) dmem_ack = 1'b1;
            end
            if (rf_we) begin
                rfc++;
                if (rf_lat == 0) rf_lat = n;
            end
            if (imem_req || halted) done = 1'b1;
        end
        start      = 1'b0;
        busy_total += n - 1;

        got_e = sbq.pop_front();
        check_eq("end_cycle", n, got_e.end_n);
        check_eq("pc", {22'd0, pc}, {22'd0, got_e.pc});
        check_eq("rf_we_count", rfc, got_e.rf);
        check_eq("dmem_cycles", dc, got_e.dcyc);
        check_eq("halted", {31'd0, halted}, {31'd0, got_e.halt});
        if (got_e.dcyc > 0) check_eq("dmem_we", {31'd0, dwe_seen}, {31'd0, got_e.dwe});
        if (got_e.rf > 0)   check_eq("rf_latency", rf_lat, got_e.end_n - 1);
        m_pc = got_e.pc;
    endtask

    initial begin
        int   n;
        int   dc;
        int   rfc;
        logic [CNT_W-1:0] cnt_snap;

        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        br_taken = 1'b0; br_target = '0; dmem_ack = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_pc", {22'd0, pc}, 32'd0);
        check_eq("rst_ir", {23'd0, ir}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        check_eq("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check_eq("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check_eq("rst_count", {16'd0, cycle_count}, 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_no_req", {31'd0, imem_req}, 32'd0);

        pulse_start();
        m_pc = '0;
        busy_total = 0;
        check_eq("start_count", {16'd0, cycle_count}, 32'd0);

        run_instr(OP_ADD, 1'b0, 10'h000, 0, 1'b1);  // start while busy ignored
        run_instr(OP_LW,  1'b0, 10'h000, 3, 1'b0);
        run_instr(OP_LW,  1'b0, 10'h000, 1, 1'b0);
        run_instr(OP_SW,  1'b0, 10'h000, 2, 1'b0);
        run_instr(OP_BR,  1'b1, 10'h2A5, 0, 1'b0);
        run_instr(OP_BR,  1'b0, 10'h155, 0, 1'b0);
        run_instr(OP_BR,  1'b1, 10'h3FF, 0, 1'b0);
        run_instr(OP_ADD, 1'b0, 10'h000, 0, 1'b0);  // wraps to 0
        run_instr(OP_ADD, 1'b0, 10'h000, 0, 1'b0);
        run_instr(OP_HALT, 1'b0, 10'h000, 0, 1'b0);

        check_eq("halt_count", {16'd0, cycle_count}, busy_total);
        check_eq("halt_busy", {31'd0, busy}, 32'd0);
        cnt_snap = cycle_count;
        repeat (5) @(negedge clk);
        check_eq("halt_count_frozen", {16'd0, cycle_count}, {16'd0, cnt_snap});
        check_eq("halt_pc_held", {22'd0, pc}, {22'd0, m_pc});
        check_eq("halt_no_req", {31'd0, imem_req}, 32'd0);

        pulse_start();
        check_eq("restart_pc", {22'd0, pc}, 32'd0);
        check_eq("restart_count", {16'd0, cycle_count}, 32'd0);
        check_eq("restart_halted", {31'd0, halted}, 32'd0);
        m_pc = '0;

        // Reset while waiting in MEM
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        imem_ack   = 1'b1;
        imem_rdata = {OP_LW, 6'h00};
        dc = 0; n = 0; rfc = 0;
        while (dc < 2 && n < 30) begin
            @(negedge clk);
            imem_ack = 1'b0;
            n++;
            if (dmem_req) dc++;
        end
        check_eq("mem_wait_reached", dc, 2);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_ir", {23'd0, ir}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (rf_we) rfc++;
        end
        check_eq("arst_no_rf_we", rfc, 0);
        check_eq("arst_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_core_sequencer
`default_nettype wire
